// File: rtl/ttt_pkg.sv
// Shared board constants, cell codes and the frame arbiter state encoding.
package ttt_pkg;

  localparam int unsigned NCELLS = 9;
  localparam int unsigned AW     = 4;
  localparam int unsigned CW     = 2;
  localparam int unsigned GW     = 10;

  localparam logic [CW-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CW-1:0] CELL_P1    = 2'b01;
  localparam logic [CW-1:0] CELL_P2    = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    CLEAR
  } arb_state_t;

endpackage

// File: rtl/board_regfile.sv
// NCELLS x CW cell store: one write/clear port, one asynchronous read port.
// Out-of-range addresses write nothing and read as empty.
module board_regfile
  import ttt_pkg::*;
#(
  parameter int unsigned NCells = NCELLS,
  parameter int unsigned Cw     = CW,
  parameter int unsigned Aw     = AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          clr_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [Cw-1:0] wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [Cw-1:0] rdata_o
);

  logic [Cw-1:0] mem_q [NCells];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NCells); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NCells); i++) begin
        // Clear takes precedence over a data write to the same cell.
        if ((we_i || clr_i) && (waddr_i == Aw'(i))) begin
          mem_q[i] <= clr_i ? '0 : wdata_i;
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < int'(NCells); i++) begin
      if (raddr_i == Aw'(i)) begin
        rdata_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/board_frame_arbiter.sv
// Live/display double-buffered board: game writes live, VGA reads display,
// live is copied to display one cell per clock after each frame-end pulse.
module board_frame_arbiter
  import ttt_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [CW-1:0] wr_data_i,
  output logic          wr_ack_o,
  input  logic          clr_req_i,
  input  logic [GW-1:0] gameover_i,
  input  logic          save_i,
  input  logic [AW-1:0] saddr_i,
  output logic [CW-1:0] sprite_o,
  output logic [GW-1:0] gameover_o,
  output logic          busy_o
);

  localparam logic [AW-1:0] LastIdx = AW'(NCELLS - 1);

  arb_state_t    state_q;
  logic [AW-1:0] idx_q;
  logic          save_pend_q;
  logic [CW-1:0] sprite_q;
  logic [GW-1:0] gameover_q;

  logic          live_we, live_clr, disp_we, disp_clr;
  logic [AW-1:0] live_waddr;
  logic [CW-1:0] live_rdata, disp_rdata;

  // Ack is combinational so a held request is accepted in the same cycle the
  // write happens, and never twice for one request.
  assign wr_ack_o = (state_q == IDLE) && wr_req_i && !clr_req_i && !save_i && !save_pend_q;

  assign live_we    = wr_ack_o;
  assign live_clr   = (state_q == CLEAR);
  assign live_waddr = live_clr ? idx_q : wr_addr_i;
  assign disp_we    = (state_q == COPY) && !clr_req_i;
  assign disp_clr   = (state_q == CLEAR);

  board_regfile #(
    .NCells(NCELLS),
    .Cw    (CW),
    .Aw    (AW)
  ) u_live (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (live_we),
    .clr_i  (live_clr),
    .waddr_i(live_waddr),
    .wdata_i(wr_data_i),
    .raddr_i(idx_q),
    .rdata_o(live_rdata)
  );

  board_regfile #(
    .NCells(NCELLS),
    .Cw    (CW),
    .Aw    (AW)
  ) u_disp (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (disp_we),
    .clr_i  (disp_clr),
    .waddr_i(idx_q),
    .wdata_i(live_rdata),
    .raddr_i(saddr_i),
    .rdata_o(disp_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      save_pend_q <= 1'b0;
      sprite_q    <= '0;
      gameover_q  <= '0;
    end else begin
      sprite_q <= disp_rdata;
      unique case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            if (save_i) save_pend_q <= 1'b1;
          end else if (save_i || save_pend_q) begin
            state_q     <= COPY;
            idx_q       <= '0;
            save_pend_q <= 1'b0;
          end
        end
        COPY: begin
          if (save_i) save_pend_q <= 1'b1;
          if (clr_req_i) begin
            state_q <= CLEAR;
            idx_q   <= '0;
          end else if (idx_q == LastIdx) begin
            gameover_q <= gameover_i;
            state_q    <= IDLE;
            idx_q      <= '0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        CLEAR: begin
          if (save_i) save_pend_q <= 1'b1;
          if (idx_q == LastIdx) begin
            gameover_q <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign sprite_o   = sprite_q;
  assign gameover_o = gameover_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_board_frame_arbiter.sv
// Directed self-checking bench for board_frame_arbiter.
module tb_board_frame_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_req_i;
  logic [3:0] wr_addr_i;
  logic [1:0] wr_data_i;
  logic       wr_ack_o;
  logic       clr_req_i;
  logic [9:0] gameover_i;
  logic       save_i;
  logic [3:0] saddr_i;
  logic [1:0] sprite_o;
  logic [9:0] gameover_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  board_frame_arbiter dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_req_i  (wr_req_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .wr_ack_o  (wr_ack_o),
    .clr_req_i (clr_req_i),
    .gameover_i(gameover_i),
    .save_i    (save_i),
    .saddr_i   (saddr_i),
    .sprite_o  (sprite_o),
    .gameover_o(gameover_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Holds a request until acked (bounded); checks the ack arrives and is one cycle.
  task automatic do_write(input string tag, input logic [3:0] a, input logic [1:0] d);
    int n;
    wr_req_i  = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    n = 0;
    @(negedge clk_i);
    while (!wr_ack_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_ack"}, wr_ack_o, 1);
    tick();
    wr_req_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_ack_once"}, wr_ack_o, 0);
    tick();
  endtask

  task automatic pulse_save();
    save_i = 1'b1;
    tick();
    save_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
  endtask

  // Counts busy cycles from the current cycle on; ends in the first idle cycle.
  task automatic busy_run(output int n);
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    tick();
  endtask

  task automatic read_cell(input string tag, input logic [3:0] a, input logic [1:0] exp);
    saddr_i = a;
    tick();
    check(tag, sprite_o, exp);
  endtask

  int nb;
  int acks_in_copy;

  initial begin
    rst_i = 1'b1;
    wr_req_i = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    clr_req_i = 1'b0;
    gameover_i = '0;
    save_i = 1'b0;
    saddr_i = '0;
    #23;
    check("rst_sprite", sprite_o, 0);
    check("rst_gameover", gameover_o, 0);
    check("rst_ack", wr_ack_o, 0);
    check("rst_busy", busy_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Write then save
    do_write("w3", 4'd3, 2'b01);
    do_write("w7", 4'd7, 2'b10);
    pulse_save();
    busy_run(nb);
    check("copy_len", nb, 9);
    read_cell("rd3", 4'd3, 2'b01);
    read_cell("rd7", 4'd7, 2'b10);
    read_cell("rd0", 4'd0, 2'b00);

    // Tearing guard
    do_write("w4", 4'd4, 2'b01);
    read_cell("tear_before", 4'd4, 2'b00);
    pulse_save();
    busy_run(nb);
    read_cell("tear_after", 4'd4, 2'b01);

    // Stall during copy; ack on first idle cycle
    pulse_save();
    wr_req_i = 1'b1;
    wr_addr_i = 4'd5;
    wr_data_i = 2'b10;
    nb = 0;
    acks_in_copy = 0;
    @(negedge clk_i);
    while (busy_o && nb < 100) begin
      nb++;
      if (wr_ack_o) acks_in_copy++;
      @(negedge clk_i);
    end
    check("stall_busy", nb, 9);
    check("stall_noack", acks_in_copy, 0);
    check("stall_ack_idle", wr_ack_o, 1);
    tick();
    wr_req_i = 1'b0;
    pulse_save();
    busy_run(nb);
    read_cell("stall_rd5", 4'd5, 2'b10);

    // Clear with gameover snapshot
    gameover_i = 10'h3FF;
    pulse_save();
    busy_run(nb);
    check("go_snap", gameover_o, 10'h3FF);
    pulse_clr();
    busy_run(nb);
    check("clr_len", nb, 9);
    check("clr_go", gameover_o, 0);
    read_cell("clr_rd3", 4'd3, 2'b00);
    read_cell("clr_rd7", 4'd7, 2'b00);
    read_cell("clr_rd5", 4'd5, 2'b00);
    pulse_save();
    busy_run(nb);
    read_cell("clr_live3", 4'd3, 2'b00);
    check("clr_go_copy", gameover_o, 10'h3FF);

    // Save during CLEAR
    pulse_clr();
    tick();
    pulse_save();
    busy_run(nb);
    check("sdc_clr_rest", nb, 7);
    busy_run(nb);
    check("sdc_copy", nb, 9);
    @(negedge clk_i);
    check("sdc_idle", busy_o, 0);
    tick();

    // clr_req mid-COPY at idx 4
    do_write("w2", 4'd2, 2'b10);
    pulse_save();
    busy_run(nb);
    read_cell("mc_rd2", 4'd2, 2'b10);
    pulse_save();
    tick(); tick(); tick(); tick();
    pulse_clr();
    busy_run(nb);
    check("mc_clr_len", nb, 9);
    read_cell("mc_rd2_clr", 4'd2, 2'b00);

    // clr_req + save together: CLEAR then COPY (gameover proves order)
    gameover_i = 10'h2A5;
    do_write("w6", 4'd6, 2'b01);
    clr_req_i = 1'b1;
    save_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    save_i = 1'b0;
    busy_run(nb);
    check("cs_clr_len", nb, 9);
    busy_run(nb);
    check("cs_copy_len", nb, 9);
    check("cs_go", gameover_o, 10'h2A5);
    read_cell("cs_rd6", 4'd6, 2'b00);

    // Reset mid-COPY
    do_write("w8", 4'd8, 2'b10);
    pulse_save();
    busy_run(nb);
    read_cell("rm_rd8", 4'd8, 2'b10);
    pulse_save();
    tick(); tick();
    rst_i = 1'b1;
    #1;
    check("rm_sprite", sprite_o, 0);
    check("rm_go", gameover_o, 0);
    check("rm_busy", busy_o, 0);
    check("rm_ack", wr_ack_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    read_cell("rm_rd8_after", 4'd8, 2'b00);

    // Out-of-range write and read
    do_write("w12", 4'd12, 2'b11);
    do_write("w7b", 4'd7, 2'b11);
    pulse_save();
    busy_run(nb);
    for (int i = 0; i < 9; i++) begin
      read_cell($sformatf("oob_rd%0d", i), 4'(i), (i == 7) ? 2'b11 : 2'b00);
    end
    read_cell("oob_rd15", 4'd15, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
